// File: rtl/pulpino_deser_rx.sv
// Beat-to-word deserialiser: toggle/echo beat handshake, LSB-beat-first assembly, FWFT output FIFO.
// Optional trailing XOR checksum beat enabled by PULPINO_DESER_CHECKSUM_EN.
module pulpino_deser_rx #(
  parameter int BEAT_W = 8,
  parameter int BEATS  = 4,
  parameter int DEPTH  = 2
) (
  input  logic                       i_clk,
  input  logic                       i_rst_n,
  input  logic [BEAT_W-1:0]          i_in_data,
  input  logic                       i_word_req,
  input  logic                       i_beat_tgl,
  output logic                       o_beat_ack,
  output logic                       o_word_ack,
  output logic [BEAT_W*BEATS-1:0]    o_out_word,
  output logic                       o_out_valid,
  input  logic                       i_out_ready,
  output logic [$clog2(DEPTH+1)-1:0] o_fill,
  output logic                       o_err
);

  localparam int WORD_W = BEAT_W * BEATS;
  localparam int FILL_W = $clog2(DEPTH + 1);
  localparam int PTR_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
`ifdef PULPINO_DESER_CHECKSUM_EN
  localparam int NBEATS = BEATS + 1;
`else
  localparam int NBEATS = BEATS;
`endif
  localparam int CNT_W  = $clog2(NBEATS + 1);

  typedef enum logic [1:0] {S_IDLE, S_COLLECT, S_CHECK, S_DONE} state_t;

`ifdef PULPINO_DESER_CHECKSUM_EN
  localparam state_t S_AFTER = S_CHECK;
`else
  localparam state_t S_AFTER = S_DONE;
`endif

  state_t              r_state;
  logic [CNT_W-1:0]    r_cnt;
  logic                r_beat_ack;
  logic                r_word_ack;
  logic [WORD_W-1:0]   r_asm;

  logic [WORD_W-1:0]   r_mem [DEPTH];
  logic [PTR_W-1:0]    r_wptr;
  logic [PTR_W-1:0]    r_rptr;
  logic [FILL_W-1:0]   r_fill;
  logic [WORD_W-1:0]   r_out_word;
  logic                r_out_valid;

  logic                w_pending;
  logic                w_chk_ok;
  logic                w_push;
  logic                w_pop;
  logic                w_space;
  logic [FILL_W-1:0]   w_fill_next;

  assign w_pending   = i_beat_tgl ^ r_beat_ack;
  assign w_space     = r_fill < FILL_W'(DEPTH);
  assign w_push      = (r_state == S_DONE) && !r_word_ack && w_chk_ok;
  assign w_pop       = i_out_ready && (r_fill != '0);
  assign w_fill_next = r_fill + FILL_W'(w_push) - FILL_W'(w_pop);

`ifdef PULPINO_DESER_CHECKSUM_EN
  logic [BEAT_W-1:0] r_chk;
  logic              r_chk_ok;
  logic              r_err;
  logic [BEAT_W-1:0] w_xor;

  always_comb begin
    w_xor = '0;
    for (int i = 0; i < BEATS; i++) begin
      w_xor = w_xor ^ r_asm[i*BEAT_W +: BEAT_W];
    end
  end

  // Checksum beat lands one slot past the data; compare result is registered before DONE uses it.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_chk    <= '0;
      r_chk_ok <= 1'b0;
      r_err    <= 1'b0;
    end else begin
      if (r_state == S_COLLECT && i_word_req && w_pending && r_cnt == CNT_W'(BEATS))
        r_chk <= i_in_data;
      if (r_state == S_CHECK)
        r_chk_ok <= (w_xor == r_chk);
      if (r_state == S_DONE && !r_word_ack && !r_chk_ok)
        r_err <= 1'b1;
    end
  end

  assign w_chk_ok = r_chk_ok;
  assign o_err    = r_err;
`else
  assign w_chk_ok = 1'b1;
  assign o_err    = 1'b0;
`endif

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state    <= S_IDLE;
      r_cnt      <= '0;
      r_beat_ack <= 1'b0;
      r_word_ack <= 1'b0;
      r_asm      <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          r_word_ack <= 1'b0;
          // Entry reserves a FIFO slot, so the later push can never overflow.
          if (i_word_req && w_space) begin
            r_asm   <= '0;
            r_cnt   <= '0;
            r_state <= S_COLLECT;
          end
        end
        S_COLLECT: begin
          if (!i_word_req) begin
            r_state <= S_IDLE;
          end else if (w_pending) begin
            if (r_cnt < CNT_W'(BEATS))
              r_asm[r_cnt*BEAT_W +: BEAT_W] <= i_in_data;
            r_beat_ack <= i_beat_tgl;
            r_cnt      <= r_cnt + CNT_W'(1);
            if (r_cnt == CNT_W'(NBEATS - 1))
              r_state <= S_AFTER;
          end
        end
        S_CHECK: begin
          r_state <= S_DONE;
        end
        S_DONE: begin
          if (!r_word_ack) begin
            r_word_ack <= 1'b1;
          end else if (!i_word_req) begin
            r_word_ack <= 1'b0;
            r_state    <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  always_ff @(posedge i_clk) begin
    if (w_push)
      r_mem[r_wptr] <= r_asm;
  end

  // Head register keeps its last value when the FIFO drains empty.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_wptr      <= '0;
      r_rptr      <= '0;
      r_fill      <= '0;
      r_out_word  <= '0;
      r_out_valid <= 1'b0;
    end else begin
      if (w_push)
        r_wptr <= r_wptr + PTR_W'(1);
      if (w_pop)
        r_rptr <= r_rptr + PTR_W'(1);
      r_fill      <= w_fill_next;
      r_out_valid <= (w_fill_next != '0);
      if (w_pop) begin
        if (r_fill > FILL_W'(1))
          r_out_word <= r_mem[r_rptr + PTR_W'(1)];
        else if (w_push)
          r_out_word <= r_asm;
      end else if (w_push && r_fill == '0) begin
        r_out_word <= r_asm;
      end
    end
  end

  assign o_beat_ack  = r_beat_ack;
  assign o_word_ack  = r_word_ack;
  assign o_out_word  = r_out_word;
  assign o_out_valid = r_out_valid;
  assign o_fill      = r_fill;

endmodule

// File: tb/tb_pulpino_deser_rx.sv
// Scoreboard bench for pulpino_deser_rx: stimulus enqueues expected words, a negedge monitor checks pops.
// Also exercises the PULPINO_DESER_CHECKSUM_EN build when that macro is defined.
module tb_pulpino_deser_rx;

`ifdef PULPINO_DESER_CHECKSUM_EN
  localparam int NB = 5;
`else
  localparam int NB = 4;
`endif

  logic        clk = 1'b0;
  logic        rst_n;
  logic [7:0]  in_data;
  logic        word_req;
  logic        beat_tgl;
  logic        beat_ack;
  logic        word_ack;
  logic [31:0] out_word;
  logic        out_valid;
  logic        out_ready;
  logic [1:0]  fill;
  logic        err;

  int n_checks = 0;
  int n_errors = 0;
  logic [31:0] sb[$];

  always #5 clk = ~clk;

  pulpino_deser_rx #(.BEAT_W(8), .BEATS(4), .DEPTH(2)) dut (
    .i_clk       (clk),
    .i_rst_n     (rst_n),
    .i_in_data   (in_data),
    .i_word_req  (word_req),
    .i_beat_tgl  (beat_tgl),
    .o_beat_ack  (beat_ack),
    .o_word_ack  (word_ack),
    .o_out_word  (out_word),
    .o_out_valid (out_valid),
    .i_out_ready (out_ready),
    .o_fill      (fill),
    .o_err       (err)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end else begin
      $display("ok   %s: %h", name, act);
    end
  endtask

  // Pop happens on the next posedge whenever valid & ready are seen here.
  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) begin
      if (sb.size() == 0) begin
        n_checks++;
        n_errors++;
        $display("FAIL sb_unexpected_pop: got %h, expected no word", out_word);
      end else begin
        check("sb_pop_word", out_word, sb.pop_front());
      end
    end
  end

  function automatic logic [7:0] beat_of(input logic [31:0] w, input int i, input bit bad);
    logic [7:0] x;
    if (i < 4) return w[8*i +: 8];
    x = w[7:0] ^ w[15:8] ^ w[23:16] ^ w[31:24];
    return x ^ {7'd0, bad};
  endfunction

  // which: 0 = beat_ack, 1 = word_ack, 2 = fill==0
  task automatic wait_sig(input int which, input logic val, input string name);
    bit ok = 0;
    logic cur;
    for (int i = 0; i < 60 && !ok; i++) begin
      @(negedge clk);
      cur = (which == 0) ? beat_ack : (which == 1) ? word_ack : (fill == 2'd0);
      if (cur == val) ok = 1;
    end
    n_checks++;
    if (!ok) begin
      n_errors++;
      $display("FAIL timeout_%s: got no change, expected %0b", name, val);
    end
  endtask

  task automatic drive_beat(input logic [7:0] d);
    @(posedge clk); #1;
    in_data  = d;
    beat_tgl = ~beat_tgl;
  endtask

  task automatic send_beat(input logic [7:0] d);
    drive_beat(d);
    wait_sig(0, beat_tgl, "beat_ack");
  endtask

  task automatic begin_word(input logic [31:0] w, input int nsend, input bit push, input bit bad);
    if (push) sb.push_back(w);
    @(posedge clk); #1;
    word_req = 1'b1;
    for (int i = 0; i < nsend; i++) send_beat(beat_of(w, i, bad));
  endtask

  task automatic end_word(input int hold);
    wait_sig(1, 1'b1, "word_ack_rise");
    if (hold > 0) begin
      repeat (hold) @(negedge clk);
      check("word_ack_held", {31'd0, word_ack}, 32'd1);
    end
    @(posedge clk); #1;
    word_req = 1'b0;
    wait_sig(1, 1'b0, "word_ack_fall");
  endtask

  task automatic send_word(input logic [31:0] w);
    begin_word(w, NB, 1, 0);
    end_word(0);
  endtask

  task automatic drain();
    @(posedge clk); #1;
    out_ready = 1'b1;
    wait_sig(2, 1'b1, "drain");
    @(posedge clk); #1;
    out_ready = 1'b0;
    check("sb_empty", sb.size(), 32'd0);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; word_req = 1'b0; beat_tgl = 1'b0; in_data = 8'h00; out_ready = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_beat_ack", {31'd0, beat_ack}, 32'd0);
    check("rst_word_ack", {31'd0, word_ack}, 32'd0);
    check("rst_out_valid", {31'd0, out_valid}, 32'd0);
    check("rst_fill", {30'd0, fill}, 32'd0);
    check("rst_out_word", out_word, 32'd0);
    check("rst_err", {31'd0, err}, 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;

    // Single word, word_ack held until word_req drops
    begin_word(32'h44332211, NB, 1, 0);
    wait_sig(1, 1'b1, "word_ack_rise");
    check("t1_out_word", out_word, 32'h44332211);
    check("t1_out_valid", {31'd0, out_valid}, 32'd1);
    check("t1_fill", {30'd0, fill}, 32'd1);
    check("t1_beat_ack", {31'd0, beat_ack}, (NB == 4) ? 32'd0 : 32'd1);
    end_word(3);
    drain();

    // FIFO full stalls the third word; one pop lets it proceed
    send_word(32'hDEADBEEF);
    send_word(32'h12345678);
    check("t2_fill_full", {30'd0, fill}, 32'd2);
    sb.push_back(32'hCAFEF00D);
    @(posedge clk); #1;
    word_req = 1'b1;
    in_data  = beat_of(32'hCAFEF00D, 0, 0);
    beat_tgl = ~beat_tgl;
    repeat (6) @(negedge clk);
    check("t2_beat_ack_stalled", {31'd0, beat_ack}, {31'd0, !beat_tgl});
    check("t2_fill_stalled", {30'd0, fill}, 32'd2);
    @(posedge clk); #1;
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    wait_sig(0, beat_tgl, "beat_ack");
    check("t2_fill_after_pop", {30'd0, fill}, 32'd1);
    for (int i = 1; i < NB; i++) send_beat(beat_of(32'hCAFEF00D, i, 0));
    end_word(0);
    check("t2_fill_after_third", {30'd0, fill}, 32'd2);
    drain();
    check("t2_empty_valid", {31'd0, out_valid}, 32'd0);
    check("t2_hold_last", out_word, 32'hCAFEF00D);

    // Abort after two beats
    begin_word(32'h55667788, 2, 0, 0);
    @(posedge clk); #1;
    word_req = 1'b0;
    repeat (3) @(negedge clk);
    check("t3_fill", {30'd0, fill}, 32'd0);
    check("t3_word_ack", {31'd0, word_ack}, 32'd0);
    check("t3_beat_ack", {31'd0, beat_ack}, {31'd0, beat_tgl});
    send_word(32'hA5A5A5A5);
    check("t3_out_word", out_word, 32'hA5A5A5A5);
    check("t3_fill_one", {30'd0, fill}, 32'd1);

    // Async reset mid-COLLECT with one word queued
    begin_word(32'h76543210, 2, 0, 0);
    #3;
    rst_n = 1'b0;
    #1;
    check("t4_beat_ack", {31'd0, beat_ack}, 32'd0);
    check("t4_word_ack", {31'd0, word_ack}, 32'd0);
    check("t4_out_valid", {31'd0, out_valid}, 32'd0);
    check("t4_fill", {30'd0, fill}, 32'd0);
    check("t4_out_word", out_word, 32'd0);
    sb.delete();
    beat_tgl = 1'b0; word_req = 1'b0; in_data = 8'h00;
    @(posedge clk); #1;
    rst_n = 1'b1;
    send_word(32'h0BADF00D);
    check("t4_next_word", out_word, 32'h0BADF00D);
    drain();

    // Push and pop on the same edge at fill=1
    send_word(32'h11112222);
    begin_word(32'h33334444, NB - 1, 1, 0);
    drive_beat(beat_of(32'h33334444, NB - 1, 0));
    @(posedge clk); #1;
`ifdef PULPINO_DESER_CHECKSUM_EN
    @(posedge clk); #1;
`endif
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check("t5_fill", {30'd0, fill}, 32'd1);
    check("t5_out_word", out_word, 32'h33334444);
    check("t5_word_ack", {31'd0, word_ack}, 32'd1);
    @(posedge clk); #1;
    word_req = 1'b0;
    wait_sig(1, 1'b0, "word_ack_fall");
    drain();

`ifdef PULPINO_DESER_CHECKSUM_EN
    // Good checksum pushes, bad checksum sets sticky err without a push
    send_word(32'h08040201);
    check("t6_good_fill", {30'd0, fill}, 32'd1);
    check("t6_good_err", {31'd0, err}, 32'd0);
    drain();
    begin_word(32'h08040201, NB, 0, 1);
    wait_sig(1, 1'b1, "word_ack_bad");
    check("t6_bad_fill", {30'd0, fill}, 32'd0);
    check("t6_bad_err", {31'd0, err}, 32'd1);
    @(posedge clk); #1;
    word_req = 1'b0;
    wait_sig(1, 1'b0, "word_ack_fall");
    check("t6_err_sticky", {31'd0, err}, 32'd1);
`else
    check("t6_err_tied", {31'd0, err}, 32'd0);
`endif

    repeat (2) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/pulpino_deser_rx.md
# pulpino_deser_rx

Parametrised beat-to-word deserialiser for the host-to-PULPino data path on the CW305 top level. It accepts BEATS beats of BEAT_W bits over a level/toggle handshake (word-level request/acknowledge, per-beat toggle/echo) and assembles them LSB-beat-first into one word. Each completed word is pushed into a DEPTH-entry output FIFO with a valid/ready interface. The block stalls new words while the FIFO is full. It is fully registered: no combinational next-state latches.

## Interface
- BEAT_W, 8, bits per beat.
- BEATS, 4, data beats per word (≥2).
- DEPTH, 2, output FIFO entries (power of two, ≥2).
- clk  in  1  sole clock; all inputs synchronous to it.
- rst_n  in  1  reset; asynchronous, active-low.
- in_data  in  BEAT_W  beat payload; stable from the cycle beat_tgl changes until beat_ack matches.
- word_req  in  1  writer level; high = word transfer in progress.
- beat_tgl  in  1  writer toggles once per beat.
- beat_ack  out  1  reader echo of beat_tgl; equal means beat consumed.
- word_ack  out  1  high = full word received; held until word_req falls.
- out_word  out  BEAT_W*BEATS  FIFO head word.
- out_valid  out  1  FIFO non-empty.
- out_ready  in  1  consumer pops head when out_valid & out_ready.
- fill  out  $clog2(DEPTH+1)  current FIFO occupancy.
- err  out  1  sticky checksum error (see Configuration).

## Operation
- Reset values: state IDLE, beat counter 0, beat_ack 0, word_ack 0, out_word 0, out_valid 0, fill 0, err 0, assembly register 0.
- IDLE: word_ack 0. If word_req=1 and fill<DEPTH, clear the assembly register and counter, then go to COLLECT. If the FIFO is full, stay in IDLE; the writer sees no beat_ack movement.
- COLLECT: a beat is pending when beat_tgl≠beat_ack. On a pending beat:
  - Write in_data into slot cnt; beat 0 goes to bits [BEAT_W-1:0].
  - Set beat_ack←beat_tgl and increment cnt.
  - After the last data beat, go to DONE (or CHECK, with the macro).
- Toggle parity runs continuously across words. beat_ack is never re-zeroed outside reset.
- DONE: push the assembled word into the FIFO and set word_ack=1. When word_req=0, clear word_ack and go to IDLE.
- Abort: if word_req falls while in COLLECT, discard the partial word (no push) and return to IDLE. A pending beat in that same cycle is ignored, and beat_ack keeps its value.
- FIFO slot is reserved at word start: entry to COLLECT requires space, and pops only free space, so a push can never overflow.
- Push and pop in the same cycle leave fill unchanged. A pop when empty is ignored.
- The FIFO is first-word-fall-through: out_word holds the oldest entry. When empty, out_word holds its last value.

## Timing
- beat_ack updates 1 cycle after the cycle in which the beat_tgl change is sampled. Maximum rate is 1 beat per 2 cycles for a writer that waits on the echo.
- word_ack rises 1 cycle after the last beat is captured (2 cycles with the checksum). It falls 1 cycle after word_req=0 is sampled.
- Pushed word: out_valid=1 and fill incremented on the same edge word_ack rises.
- IDLE→COLLECT takes 1 cycle after word_req=1 is sampled with space available.
- Asynchronous reset mid-word: all state returns to reset values immediately. The partial word and FIFO contents are lost.

## Configuration
- PULPINO_DESER_CHECKSUM_EN defined:
  - The writer sends BEATS+1 beats; the extra final beat is the XOR of the BEATS data beats.
  - CHECK state compares the received checksum with the computed one.
  - On match: push the word, as in DONE.
  - On mismatch: do not push, set err=1 (sticky until reset), and still assert word_ack so the handshake completes.
- Undefined: exactly BEATS beats per word, no CHECK state, err tied to 0.

## Test plan
- Reset, then one word of beats 0x11,0x22,0x33,0x44 (beat_tgl 1,0,1,0) -> out_word=0x44332211, out_valid=1, fill=1, word_ack high until word_req drops, beat_ack ends at 0.
- Three back-to-back words with DEPTH=2 and out_ready=0 -> third word_req gets no beat_ack change while fill=2. Assert out_ready for 1 cycle -> fill=1, third word completes, FIFO order preserved.
- word_req dropped after 2 beats -> no push, fill unchanged, state IDLE. Next full word 0xA5A5A5A5 is captured correctly with continued toggle parity.
- Assert rst_n low mid-COLLECT with 1 word queued -> all outputs 0 asynchronously. Next word after release is received cleanly.
- Checksum build: beats 0x01,0x02,0x04,0x08, check 0x0F -> pushed, err=0. Same data with check 0x0E -> no push, err=1, word_ack still pulses.
- Simultaneous push and pop at fill=1 -> fill stays 1, out_word advances to the new word.
